// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: start/branch control in, ROM address out, ROM data in, decoded-side outputs.
// No storage; pure signal grouping.
// Flow control is stall-based (stall_i freezes the stage); no ready/valid back-pressure here.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 16
);
  logic               start_i;
  logic [ADDR_W-1:0]  start_addr_i;
  logic               stall_i;
  logic               branch_taken_i;
  logic               branch_back_i;
  logic [ADDR_W-1:0]  branch_off_i;
  logic [ADDR_W-1:0]  rom_addr_o;
  logic [INSTR_W-1:0] rom_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  instr_pc_o;
  logic               instr_valid_o;
  logic               done_o;
  logic [CNT_W-1:0]   retired_o;

  // Fetch unit side
  modport slave (
    input  start_i, start_addr_i, stall_i, branch_taken_i, branch_back_i, branch_off_i,
    input  rom_data_i,
    output rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, retired_o
  );

  // Execute / ROM / top-level side
  modport master (
    output start_i, start_addr_i, stall_i, branch_taken_i, branch_back_i, branch_off_i,
    output rom_data_i,
    input  rom_addr_o, instr_o, instr_pc_o, instr_valid_o, done_o, retired_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter + fetch register in front of the instruction ROM; resolves relative branches, detects halt.
// Latency: ROM word for pc appears on instr_o one cycle later; each taken branch costs one bubble.
// Backpressure: stall_i freezes pc and the fetch register; branches are ignored while stalled.
module instr_fetch_unit #(
  parameter int                 ADDR_W      = 8,
  parameter int                 INSTR_W     = 8,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'h88,
  parameter int                 CNT_W       = 16
) (
  input logic                 clk_i,
  input logic                 reset_i,
  instr_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               valid_q;
  logic               done_q;
  logic [CNT_W-1:0]   retired_q;

  logic               accept;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  branch_target;
  logic [CNT_W-1:0]   retired_inc;

  // Execute consumes the registered instruction whenever it is live and not stalled.
  assign accept        = valid_q & ~bus.stall_i;
  // Branch distance is relative to the instruction after the branch; wraps mod 2^ADDR_W.
  assign seq_pc        = instr_pc_q + ADDR_W'(1);
  assign branch_target = bus.branch_back_i ? (seq_pc - bus.branch_off_i)
                                           : (seq_pc + bus.branch_off_i);
  // Retired counter sticks at all-ones rather than wrapping.
  assign retired_inc   = (retired_q == '1) ? retired_q : (retired_q + CNT_W'(1));

  assign bus.rom_addr_o    = pc;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.done_o        = done_q;
  assign bus.retired_o     = retired_q;

  // Fetch FSM: start/restart, sequential fetch, branch redirect with flush, halt detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      pc         <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start_i) begin
            pc        <= bus.start_addr_i;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
            state     <= S_RUN;
          end else if (accept) begin
            // Only the halt word can be pending here; once taken, nothing is live.
            retired_q <= retired_inc;
            valid_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!bus.stall_i) begin
            if (accept) begin
              retired_q <= retired_inc;
            end
            if (accept && bus.branch_taken_i) begin
              // The word at pc is on the wrong path (even if it is halt): drop it.
              pc      <= branch_target;
              valid_q <= 1'b0;
            end else begin
              instr_q    <= bus.rom_data_i;
              instr_pc_q <= pc;
              valid_q    <= 1'b1;
              if (bus.rom_data_i == HALT_OPCODE) begin
                // pc stays parked on the halt address.
                state  <= S_HALT;
                done_q <= 1'b1;
              end else begin
                pc <= pc + ADDR_W'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;

  instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8), .CNT_W(16)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .HALT_OPCODE(8'h88), .CNT_W(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] rom [256];
  assign bus.rom_data_i = rom[bus.rom_addr_o];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int src;
    bit back;
    int off;
    int tgt;
  } br_vec_t;

  // Reference model state (plain integers)
  int m_mode;  // 0 idle, 1 run, 2 halt
  int m_pc, m_instr, m_ipc, m_ret;
  bit m_valid, m_done;

  function automatic logic [7:0] rom_def(input int i);
    logic [7:0] v;
    v = 8'(i + 16);
    return (v == 8'h88) ? 8'h00 : v;
  endfunction

  task automatic rom_fill();
    for (int i = 0; i < 256; i++) rom[i] = rom_def(i);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    bus.start_i        = 1'b0;
    bus.start_addr_i   = '0;
    bus.stall_i        = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.branch_back_i  = 1'b0;
    bus.branch_off_i   = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    set_idle();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic start_at(input int a);
    bus.start_i      = 1'b1;
    bus.start_addr_i = 8'(a);
    tick();
    bus.start_i      = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr_o), 0);
    chk({tag, "_instr"},    32'(bus.instr_o), 0);
    chk({tag, "_instr_pc"}, 32'(bus.instr_pc_o), 0);
    chk({tag, "_valid"},    32'(bus.instr_valid_o), 0);
    chk({tag, "_done"},     32'(bus.done_o), 0);
    chk({tag, "_retired"},  32'(bus.retired_o), 0);
  endtask

  // One cycle of the reference model, from the rules: start only outside RUN,
  // accept = live & not stalled, taken branch redirects and flushes, halt parks.
  task automatic m_step();
    bit acc;
    if (reset_i) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_done = 0; m_ret = 0;
      return;
    end
    acc = m_valid && !bus.stall_i;
    if (m_mode != 1) begin
      if (bus.start_i) begin
        m_pc = int'(bus.start_addr_i); m_valid = 0; m_done = 0; m_ret = 0; m_mode = 1;
      end else if (acc) begin
        if (m_ret < 65535) m_ret++;
        m_valid = 0;
      end
    end else if (!bus.stall_i) begin
      if (acc && m_ret < 65535) m_ret++;
      if (acc && bus.branch_taken_i) begin
        if (bus.branch_back_i) m_pc = (m_ipc + 1 - int'(bus.branch_off_i) + 256) % 256;
        else                   m_pc = (m_ipc + 1 + int'(bus.branch_off_i)) % 256;
        m_valid = 0;
      end else begin
        m_instr = int'(rom[m_pc]);
        m_ipc   = m_pc;
        m_valid = 1;
        if (m_instr == 'h88) begin
          m_mode = 2; m_done = 1;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    br_vec_t vecs [5];
    vecs[0] = '{src: 17, back: 1'b0, off: 8,   tgt: 26};
    vecs[1] = '{src: 49, back: 1'b1, off: 38,  tgt: 12};
    vecs[2] = '{src: 30, back: 1'b0, off: 0,   tgt: 31};
    vecs[3] = '{src: 5,  back: 1'b1, off: 20,  tgt: 242};
    vecs[4] = '{src: 10, back: 1'b0, off: 250, tgt: 5};

    rom_fill();
    set_idle();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk_reset_vals("por");

    // Sequential fetch from 0; a start pulse in RUN must be ignored.
    start_at(0);
    chk("t1_rom_addr0", 32'(bus.rom_addr_o), 0);
    chk("t1_valid0", 32'(bus.instr_valid_o), 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.start_i = 1'b1;
        bus.start_addr_i = 8'd200;
      end
      tick();
      bus.start_i = 1'b0;
      chk("t1_instr_pc", 32'(bus.instr_pc_o), 32'(k));
      chk("t1_instr", 32'(bus.instr_o), 32'(rom_def(k)));
      chk("t1_valid", 32'(bus.instr_valid_o), 1);
      chk("t1_rom_addr", 32'(bus.rom_addr_o), 32'(k + 1));
    end
    chk("t1_retired", 32'(bus.retired_o), 4);

    // Branch table: forward, backward, zero offset, wrap both ways.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      start_at((vecs[v].src - 2 + 256) % 256);
      repeat (3) tick();
      chk("br_pre_pc", 32'(bus.instr_pc_o), 32'(vecs[v].src));
      chk("br_pre_valid", 32'(bus.instr_valid_o), 1);
      bus.branch_taken_i = 1'b1;
      bus.branch_back_i  = vecs[v].back;
      bus.branch_off_i   = 8'(vecs[v].off);
      tick();
      set_idle();
      chk("br_bubble_valid", 32'(bus.instr_valid_o), 0);
      chk("br_rom_addr", 32'(bus.rom_addr_o), 32'(vecs[v].tgt));
      tick();
      chk("br_tgt_pc", 32'(bus.instr_pc_o), 32'(vecs[v].tgt));
      chk("br_tgt_valid", 32'(bus.instr_valid_o), 1);
      chk("br_tgt_instr", 32'(bus.instr_o), 32'(rom_def(vecs[v].tgt)));
    end

    // Halt at 110 after starting at 100, then restart at 152.
    rom[110] = 8'h88;
    do_reset();
    start_at(100);
    for (int i = 0; i < 30 && !bus.done_o; i++) tick();
    chk("halt_reached", 32'(bus.done_o), 1);
    chk("halt_instr", 32'(bus.instr_o), 32'h88);
    chk("halt_instr_pc", 32'(bus.instr_pc_o), 110);
    chk("halt_valid", 32'(bus.instr_valid_o), 1);
    chk("halt_rom_addr", 32'(bus.rom_addr_o), 110);
    chk("halt_retired_pre", 32'(bus.retired_o), 10);
    tick();
    chk("halt_valid_drop", 32'(bus.instr_valid_o), 0);
    chk("halt_retired", 32'(bus.retired_o), 11);
    tick();
    tick();
    chk("halt_pc_frozen", 32'(bus.rom_addr_o), 110);
    chk("halt_done_held", 32'(bus.done_o), 1);
    chk("halt_retired_held", 32'(bus.retired_o), 11);
    start_at(152);
    chk("restart_done", 32'(bus.done_o), 0);
    chk("restart_retired", 32'(bus.retired_o), 0);
    chk("restart_rom_addr", 32'(bus.rom_addr_o), 152);
    chk("restart_valid", 32'(bus.instr_valid_o), 0);
    tick();
    chk("restart_pc", 32'(bus.instr_pc_o), 152);
    chk("restart_valid1", 32'(bus.instr_valid_o), 1);
    rom[110] = rom_def(110);

    // Stall 3 cycles with branch asserted: frozen, branch ignored.
    do_reset();
    start_at(20);
    repeat (3) tick();
    bus.stall_i = 1'b1;
    bus.branch_taken_i = 1'b1;
    bus.branch_off_i = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(bus.instr_pc_o), 22);
      chk("stall_instr", 32'(bus.instr_o), 32'(rom_def(22)));
      chk("stall_valid", 32'(bus.instr_valid_o), 1);
      chk("stall_rom_addr", 32'(bus.rom_addr_o), 23);
      chk("stall_retired", 32'(bus.retired_o), 2);
    end
    set_idle();
    tick();
    chk("unstall_pc", 32'(bus.instr_pc_o), 23);
    chk("unstall_retired", 32'(bus.retired_o), 3);

    // PC wrap 254 -> 255 -> 0.
    do_reset();
    start_at(254);
    chk("wrap_a0", 32'(bus.rom_addr_o), 254);
    tick();
    chk("wrap_a1", 32'(bus.rom_addr_o), 255);
    tick();
    chk("wrap_a2", 32'(bus.rom_addr_o), 0);
    chk("wrap_ipc255", 32'(bus.instr_pc_o), 255);
    tick();
    chk("wrap_ipc0", 32'(bus.instr_pc_o), 0);
    chk("wrap_instr0", 32'(bus.instr_o), 32'(rom_def(0)));

    // Reset mid-RUN and during HALT.
    do_reset();
    start_at(40);
    repeat (4) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk_reset_vals("rst_run");
    rom[110] = 8'h88;
    start_at(108);
    repeat (3) tick();
    chk("rst_halt_pre_done", 32'(bus.done_o), 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk_reset_vals("rst_halt");
    rom[110] = rom_def(110);

    // Branch taken while the halt word sits at pc: branch wins.
    rom[60] = 8'h88;
    do_reset();
    start_at(57);
    repeat (3) tick();
    bus.branch_taken_i = 1'b1;
    bus.branch_off_i   = 8'd4;
    tick();
    set_idle();
    chk("brhalt_done", 32'(bus.done_o), 0);
    chk("brhalt_valid", 32'(bus.instr_valid_o), 0);
    chk("brhalt_rom_addr", 32'(bus.rom_addr_o), 64);
    tick();
    chk("brhalt_pc", 32'(bus.instr_pc_o), 64);
    chk("brhalt_done2", 32'(bus.done_o), 0);
    rom[60] = rom_def(60);

    // Randomized run against the reference model.
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 39) == 0) ? 8'h88 : 8'($urandom);
    do_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_done = 0; m_ret = 0;
    for (int c = 0; c < 3000; c++) begin
      reset_i            = ($urandom_range(0, 199) == 0);
      bus.start_i        = ($urandom_range(0, 3) == 0);
      bus.start_addr_i   = 8'($urandom);
      bus.stall_i        = ($urandom_range(0, 3) == 0);
      bus.branch_taken_i = ($urandom_range(0, 4) == 0);
      bus.branch_back_i  = 1'($urandom);
      bus.branch_off_i   = 8'($urandom);
      m_step();
      tick();
      chk("rnd_rom_addr", 32'(bus.rom_addr_o), 32'(m_pc));
      chk("rnd_instr", 32'(bus.instr_o), 32'(m_instr));
      chk("rnd_instr_pc", 32'(bus.instr_pc_o), 32'(m_ipc));
      chk("rnd_valid", 32'(bus.instr_valid_o), 32'(m_valid));
      chk("rnd_done", 32'(bus.done_o), 32'(m_done));
      chk("rnd_retired", 32'(bus.retired_o), 32'(m_ret));
    end
    reset_i = 1'b0;
    set_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
